// File: rtl/spinner_quad_gen.sv
// -----------------------------------------------------------------------------
// spinner_quad_gen
//
// Multi-channel quadrature encoder generator for spinner/paddle cores. Each
// channel accumulates signed movement deltas into a saturating backlog and
// drains it as AB quadrature steps, one step per shared step tick. A physical
// AB encoder can take over a channel: any movement on it switches the channel
// to the physical source until the next nonzero delta arrives. Optionally the
// physical encoder is regenerated at half rate (A edges only) for 600-to-300
// pulse downgrading.
//
// Ports:
//   clk_12m      in   sole clock
//   reset        in   synchronous, active-high
//   delta_valid  in   [CHANNELS]           per-channel single-cycle delta strobe
//   delta        in   [CHANNELS*DELTA_W]   signed delta, ch i at [i*DELTA_W +: DELTA_W]
//   scale        in   [2]                  global left shift of every delta (x1..x8)
//   phys_ab      in   [2*CHANNELS]         asynchronous physical encoder {B,A} per channel
//   phys_div2    in   1                    1 = regenerate physical encoder at half rate
//   quad_ab      out  [2*CHANNELS]         {B,A} quadrature to the core per channel
//   src_phys     out  [CHANNELS]           1 = channel driven by the physical encoder
//   busy         out  [CHANNELS]           1 = backlog nonzero
// -----------------------------------------------------------------------------
module spinner_quad_gen #(
  parameter int CHANNELS = 2,
  parameter int POS_W    = 12,
  parameter int DELTA_W  = 8,
  parameter int STEP_DIV = 3000
) (
  input  logic                          clk_12m,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           delta_valid,
  input  logic [CHANNELS*DELTA_W-1:0]   delta,
  input  logic [1:0]                    scale,
  input  logic [2*CHANNELS-1:0]         phys_ab,
  input  logic                          phys_div2,
  output logic [2*CHANNELS-1:0]         quad_ab,
  output logic [CHANNELS-1:0]           src_phys,
  output logic [CHANNELS-1:0]           busy
);

  localparam int CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

  // Saturation limits at the extended (POS_W+1) width; -2^(POS_W-1) is never stored.
  localparam logic signed [POS_W:0] POS_MAX = {2'b00, {(POS_W-1){1'b1}}};
  localparam logic signed [POS_W:0] POS_MIN = -POS_MAX;

  // One quadrature step. Positive order in {B,A}: 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] phase_step(input logic [1:0] ph, input logic fwd);
    logic [1:0] nxt;
    if (fwd) begin
      case (ph)
        2'b00:   nxt = 2'b01;
        2'b01:   nxt = 2'b11;
        2'b11:   nxt = 2'b10;
        default: nxt = 2'b00;
      endcase
    end else begin
      case (ph)
        2'b00:   nxt = 2'b10;
        2'b10:   nxt = 2'b11;
        2'b11:   nxt = 2'b01;
        default: nxt = 2'b00;
      endcase
    end
    return nxt;
  endfunction

  // ---------------------------------------------------------------------------
  // Shared step divider: tick is high in the cycle the counter sits at STEP_DIV-1.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == CNT_W'(STEP_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk_12m) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel datapath
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic signed [DELTA_W-1:0] d_ch;
    logic signed [POS_W-1:0]   pos_q, pos_d;
    logic signed [POS_W:0]     pos_ext, d_ext, d_shift, stp, sum;
    logic [1:0]                gen_q, gen_d;
    logic [1:0]                sync1, sync2, sync_prev;
    logic [1:0]                regen_q, regen_d;
    logic [1:0]                phys_out, quad_d, quad_q;
    logic                      phys_change, a_edge, clear_src;
    logic                      src_q, src_d, busy_q;
    logic                      step_en;

    assign d_ch = delta[i*DELTA_W +: DELTA_W];

    // Backlog update: add scaled delta, remove one step toward zero on tick.
    // NOTE: every signal written here gets a value on every path (defaults
    // first), so no latch is inferred.
    always_comb begin
      step_en = tick && (pos_q != '0);
      pos_ext = {pos_q[POS_W-1], pos_q};
      d_ext   = {{(POS_W+1-DELTA_W){d_ch[DELTA_W-1]}}, d_ch};
      d_shift = '0;
      if (delta_valid[i]) begin
        d_shift = d_ext <<< scale;
      end
      stp = '0;
      if (step_en) begin
        stp = pos_q[POS_W-1] ? '1 : {{POS_W{1'b0}}, 1'b1};
      end
      sum = pos_ext + d_shift - stp;
      if (sum > POS_MAX) begin
        pos_d = POS_MAX[POS_W-1:0];
      end else if (sum < POS_MIN) begin
        pos_d = POS_MIN[POS_W-1:0];
      end else begin
        pos_d = sum[POS_W-1:0];
      end
    end

    // Generated phase follows the sign of the backlog on each tick.
    assign gen_d = step_en ? phase_step(gen_q, ~pos_q[POS_W-1]) : gen_q;

    // Physical path: change detection compares the synchronised pair with its
    // previous value, giving a 3-cycle input-to-output latency.
    assign phys_change = (sync2 != sync_prev);
    assign a_edge      = (sync2[0] != sync_prev[0]);

    // Half-rate regeneration: only A edges step; direction is A^B after the edge.
    assign regen_d  = (phys_div2 && a_edge) ? phase_step(regen_q, sync2[0] ^ sync2[1])
                                            : regen_q;
    assign phys_out = phys_div2 ? regen_d : sync2;

    // A nonzero delta hands the channel back to the generator; it wins over a
    // simultaneous physical movement.
    assign clear_src = delta_valid[i] && (d_ch != '0);
    assign src_d     = clear_src ? 1'b0 : (phys_change ? 1'b1 : src_q);

    // Output register is fed from next-state values so a tick in cycle n is
    // visible on quad_ab in cycle n+1.
    assign quad_d = src_d ? phys_out : gen_d;

    // NOTE: every register, including the synchronisers, has an explicit reset
    // value so the block starts from a known idle 11 state.
    always_ff @(posedge clk_12m) begin
      if (reset) begin
        pos_q     <= '0;
        gen_q     <= 2'b11;
        regen_q   <= 2'b11;
        sync1     <= 2'b11;
        sync2     <= 2'b11;
        sync_prev <= 2'b11;
        src_q     <= 1'b0;
        busy_q    <= 1'b0;
        quad_q    <= 2'b11;
      end else begin
        pos_q     <= pos_d;
        gen_q     <= gen_d;
        regen_q   <= regen_d;
        sync1     <= phys_ab[2*i +: 2];
        sync2     <= sync1;
        sync_prev <= sync2;
        src_q     <= src_d;
        busy_q    <= (pos_q != '0);
        quad_q    <= quad_d;
      end
    end

    assign quad_ab[2*i +: 2] = quad_q;
    assign src_phys[i]       = src_q;
    assign busy[i]           = busy_q;
  end

endmodule
